// File: rtl/rvtu_mem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// rvtu_arb_pkg
// Shared types and defaults for the RVTU memory arbiter slice.
//   arb_state_t  : arbiter sequencing states
//   DEF_ARB_W    : default beat width
//   DEF_BURSTS   : default data beats per transaction
//   burst_w()    : beat-counter width helper ($clog2, never below 1 bit)
// ----------------------------------------------------------------------------
package rvtu_arb_pkg;

   localparam int DEF_ARB_W  = 32;
   localparam int DEF_BURSTS = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_ADDR  = 3'd2,
      ST_WBEAT = 3'd3,
      ST_RBEAT = 3'd4
   } arb_state_t;

   // A single-beat burst still needs a 1-bit counter to stay legal.
   function automatic int burst_w(input int bursts);
      return (bursts > 1) ? $clog2(bursts) : 1;
   endfunction

   localparam int DEF_BURST_W = burst_w(DEF_BURSTS);

endpackage

// File: rtl/rvtu_mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// rvtu_mem_arbiter_if
// Requester-side and M3U-side serialized bus of the RVTU memory arbiter.
//   req_read/req_write   per-requester request, held until req_ack
//   req_ack              one-cycle grant acknowledge
//   req_wdata            per-requester address/write-data beat
//   req_rdata            read beat broadcast to all requesters
//   req_rdata_valid      read beat valid, granted requester only
//   mem_read/mem_write   downstream request, held until mem_ack
//   mem_ack              downstream acknowledge
//   mem_wdata            downstream address/write-data beat
//   mem_rdata(_valid)    downstream read beat
// Modports: slave = arbiter view, master = requesters + memory view.
// ----------------------------------------------------------------------------
interface rvtu_mem_arbiter_if
   import rvtu_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ARB_W   = DEF_ARB_W
);

   logic [NUM_REQ-1:0]            req_read;
   logic [NUM_REQ-1:0]            req_write;
   logic [NUM_REQ-1:0]            req_ack;
   logic [NUM_REQ-1:0][ARB_W-1:0] req_wdata;
   logic [ARB_W-1:0]              req_rdata;
   logic [NUM_REQ-1:0]            req_rdata_valid;

   logic                          mem_read;
   logic                          mem_write;
   logic                          mem_ack;
   logic [ARB_W-1:0]              mem_wdata;
   logic [ARB_W-1:0]              mem_rdata;
   logic                          mem_rdata_valid;

   modport slave (
      input  req_read, req_write, req_wdata, mem_ack, mem_rdata, mem_rdata_valid,
      output req_ack, req_rdata, req_rdata_valid, mem_read, mem_write, mem_wdata
   );

   modport master (
      output req_read, req_write, req_wdata, mem_ack, mem_rdata, mem_rdata_valid,
      input  req_ack, req_rdata, req_rdata_valid, mem_read, mem_write, mem_wdata
   );

endinterface

// File: rtl/rvtu_mem_arbiter_rr_picker.sv
// ----------------------------------------------------------------------------
// rvtu_rr_picker
// Combinational round-robin priority encoder: returns the first set bit of
// pend at or after rr_ptr, wrapping cyclically.
//   pend    in  NUM_REQ  pending request vector
//   rr_ptr  in  IDX_W    highest-priority position
//   any     out 1        at least one request pending
//   idx     out IDX_W    selected requester (0 when none pending)
// ----------------------------------------------------------------------------
module rvtu_rr_picker
   import rvtu_arb_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] pend,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic               any,
   output logic [IDX_W-1:0]   idx
);

   int w_pos;

   // NOTE: every output of a combinational block gets a default first so no
   // path through the block leaves it unassigned, which would infer a latch.
   always_comb begin
      any   = |pend;
      idx   = '0;
      w_pos = 0;
      // Walk offsets from farthest to nearest so the nearest pending
      // requester at or after rr_ptr is the last (winning) assignment.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_pos = int'(rr_ptr) + k;
         if (w_pos >= NUM_REQ) begin
            w_pos = w_pos - NUM_REQ;
         end
         if (pend[w_pos]) begin
            idx = IDX_W'(w_pos);
         end
      end
   end

endmodule

// File: rtl/rvtu_mem_arbiter.sv
// ----------------------------------------------------------------------------
// rvtu_mem_arbiter
// Shares one serialized M3U memory port among NUM_REQ RVTU-pair requesters.
// Round-robin grant, then sequences request/ack, one address beat and BURSTS
// write or read beats, steering each beat to/from the granted requester.
//   clk          in   clock
//   rst_n        in   asynchronous active-low reset
//   bus          slave modport of rvtu_mem_arbiter_if (requester + M3U bus)
//   busy         out  high in any state other than IDLE
//   grant_id     out  current/last granted requester
//   timeout_err  out  sticky read-return timeout (RVTU_ARB_TIMEOUT_EN only)
// Optional feature macro: RVTU_ARB_TIMEOUT_EN adds a read-return watchdog of
// TIMEOUT_CYC idle cycles that completes the burst with zero beats.
// ----------------------------------------------------------------------------
module rvtu_mem_arbiter
   import rvtu_arb_pkg::*;
#(
   parameter  int NUM_REQ     = 4,
   parameter  int ARB_W       = DEF_ARB_W,
   parameter  int BURSTS      = DEF_BURSTS,
   parameter  int TIMEOUT_CYC = 1023,
   localparam int IDX_W       = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   rvtu_mem_arbiter_if.slave  bus,
   output logic               busy,
   output logic [IDX_W-1:0]   grant_id
`ifdef RVTU_ARB_TIMEOUT_EN
   ,
   output logic               timeout_err
`endif
);

   localparam int BEAT_W = burst_w(BURSTS);

   arb_state_t          r_state;
   arb_state_t          w_next_state;
   logic [IDX_W-1:0]    r_grant_id;
   logic                r_is_read;
   logic                r_mem_read;
   logic                r_mem_write;
   logic [BEAT_W-1:0]   r_beat_ctr;
   logic [IDX_W-1:0]    r_rr_ptr;

   logic                w_any;
   logic [IDX_W-1:0]    w_idx;
   logic                w_beat_last;
   logic                w_rbeat_fire;
   logic                w_synth;
   logic [IDX_W-1:0]    w_rr_next;

   logic [NUM_REQ-1:0]  w_req_ack;
   logic [NUM_REQ-1:0]  w_rdata_valid;
   logic [ARB_W-1:0]    w_rdata;
   logic [ARB_W-1:0]    w_mem_wdata;

   rvtu_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .pend   (bus.req_read | bus.req_write),
      .rr_ptr (r_rr_ptr),
      .any    (w_any),
      .idx    (w_idx)
   );

   assign w_beat_last  = (r_beat_ctr == BEAT_W'(BURSTS - 1));
   assign w_rbeat_fire = bus.mem_rdata_valid | w_synth;
   assign w_rr_next    = (r_grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;

   // -------------------------------------------------------------------------
   // Read-return watchdog
   // -------------------------------------------------------------------------
`ifdef RVTU_ARB_TIMEOUT_EN
   localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);

   logic [WAIT_W-1:0] r_wait_ctr;
   logic              r_timeout_err;

   // Once the limit is reached the counter parks there, so the rest of the
   // burst is synthesized even if a late real beat shows up.
   assign w_synth = (r_state == ST_RBEAT) && (r_wait_ctr == WAIT_W'(TIMEOUT_CYC));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wait_ctr    <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         if (r_state != ST_RBEAT) begin
            r_wait_ctr <= '0;
         end else if (!w_synth) begin
            r_wait_ctr <= bus.mem_rdata_valid ? '0 : r_wait_ctr + 1'b1;
         end
         if (w_synth) begin
            r_timeout_err <= 1'b1;
         end
      end
   end

   assign timeout_err = r_timeout_err;
`else
   assign w_synth = 1'b0;
`endif

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         ST_IDLE:  if (w_any)        w_next_state = ST_ISSUE;
         ST_ISSUE: if (bus.mem_ack)  w_next_state = ST_ADDR;
         ST_ADDR:  w_next_state = r_is_read ? ST_RBEAT : ST_WBEAT;
         ST_WBEAT: if (w_beat_last)  w_next_state = ST_IDLE;
         ST_RBEAT: if (w_rbeat_fire && w_beat_last) w_next_state = ST_IDLE;
         default:  w_next_state = ST_IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // FSM: outputs (beat steering)
   // -------------------------------------------------------------------------
   always_comb begin
      w_req_ack     = '0;
      w_rdata_valid = '0;
      w_rdata       = bus.mem_rdata;
      w_mem_wdata   = '0;
      if (r_state != ST_IDLE) begin
         w_mem_wdata = bus.req_wdata[r_grant_id];
      end
      if (r_state == ST_ISSUE) begin
         w_req_ack[r_grant_id] = bus.mem_ack;
      end
      if (r_state == ST_RBEAT) begin
         w_rdata_valid[r_grant_id] = w_rbeat_fire;
         if (w_synth) begin
            w_rdata = '0;
         end
      end
   end

   assign bus.req_ack         = w_req_ack;
   assign bus.req_rdata       = w_rdata;
   assign bus.req_rdata_valid = w_rdata_valid;
   assign bus.mem_wdata       = w_mem_wdata;
   assign bus.mem_read        = r_mem_read;
   assign bus.mem_write       = r_mem_write;
   assign busy                = (r_state != ST_IDLE);
   assign grant_id            = r_grant_id;

   // -------------------------------------------------------------------------
   // Grant, operation, beat counter and round-robin pointer
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_grant_id  <= '0;
         r_is_read   <= 1'b0;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         r_beat_ctr  <= '0;
         r_rr_ptr    <= '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  // A requester asserting both read and write is served as a read.
                  r_grant_id  <= w_idx;
                  r_is_read   <= bus.req_read[w_idx];
                  r_mem_read  <= bus.req_read[w_idx];
                  r_mem_write <= ~bus.req_read[w_idx];
               end
            end
            ST_ISSUE: begin
               if (bus.mem_ack) begin
                  r_mem_read  <= 1'b0;
                  r_mem_write <= 1'b0;
               end
            end
            ST_ADDR: begin
               r_beat_ctr <= '0;
            end
            ST_WBEAT: begin
               r_beat_ctr <= r_beat_ctr + 1'b1;
               if (w_beat_last) begin
                  r_rr_ptr <= w_rr_next;
               end
            end
            ST_RBEAT: begin
               if (w_rbeat_fire) begin
                  r_beat_ctr <= r_beat_ctr + 1'b1;
                  if (w_beat_last) begin
                     r_rr_ptr <= w_rr_next;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // The granted request must stay up for the whole ISSUE phase.
   a_req_held_until_ack: assert property (
      @(posedge clk) disable iff (!rst_n)
      (r_state == ST_ISSUE) |-> (bus.req_read[r_grant_id] | bus.req_write[r_grant_id])
   );

endmodule

// File: tb/tb_rvtu_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rvtu_mem_arbiter
// Self-checking bench for rvtu_mem_arbiter. The bench plays both the
// requesters and the M3U memory; a round-robin reference model predicts the
// grant sequence and every steered beat.
// ----------------------------------------------------------------------------
module tb_rvtu_mem_arbiter;
   import rvtu_arb_pkg::*;

   localparam int NUM_REQ = 4;
   localparam int W       = 32;
   localparam int NB      = 4;
   localparam int TO      = 8;
   localparam int IW      = $clog2(NUM_REQ);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          busy;
   logic [IW-1:0] grant_id;
`ifdef RVTU_ARB_TIMEOUT_EN
   logic          timeout_err;
`endif

   always #5 clk = ~clk;

   rvtu_mem_arbiter_if #(.NUM_REQ(NUM_REQ), .ARB_W(W)) bus ();

   rvtu_mem_arbiter #(
      .NUM_REQ     (NUM_REQ),
      .ARB_W       (W),
      .BURSTS      (NB),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus.slave),
      .busy        (busy),
      .grant_id    (grant_id)
`ifdef RVTU_ARB_TIMEOUT_EN
      ,
      .timeout_err (timeout_err)
`endif
   );

   int n_tests;
   int n_fail;

   // Reference model state: pending requests and round-robin pointer.
   bit rd_m [NUM_REQ];
   bit wr_m [NUM_REQ];
   int rr_m;
   int last_dut_g;
   int ack_dly;
   bit directed;
   bit allow_new;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int pick_next(input int rr);
      for (int k = 0; k < NUM_REQ; k++) begin
         if (rd_m[(rr + k) % NUM_REQ] || wr_m[(rr + k) % NUM_REQ]) return (rr + k) % NUM_REQ;
      end
      return -1;
   endfunction

   function automatic bit any_pending();
      for (int i = 0; i < NUM_REQ; i++) if (rd_m[i] || wr_m[i]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic apply_reqs();
      for (int i = 0; i < NUM_REQ; i++) begin
         bus.req_read[i]  = rd_m[i];
         bus.req_write[i] = wr_m[i];
      end
   endtask

   task automatic clear_reqs();
      for (int i = 0; i < NUM_REQ; i++) begin
         rd_m[i] = 1'b0;
         wr_m[i] = 1'b0;
      end
      apply_reqs();
   endtask

   // Non-granted requesters present junk so a wrong mux select is visible.
   task automatic scramble(input int g);
      for (int i = 0; i < NUM_REQ; i++) if (i != g) bus.req_wdata[i] = $urandom;
   endtask

   task automatic add_random(input int g);
      int r;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (i != g && !rd_m[i] && !wr_m[i]) begin
            r = $urandom_range(0, 7);
            if (r == 0 || r == 2) rd_m[i] = 1'b1;
            if (r == 1 || r == 2) wr_m[i] = 1'b1;
         end
      end
   endtask

   // Serves one transaction. Entered at (negedge + 1) while the DUT is IDLE.
   task automatic serve_one();
      int            g, cyc, dly, b, gap;
      bit            is_rd, v;
      logic [W-1:0]  d;
      g     = pick_next(rr_m);
      is_rd = rd_m[g];
      cyc   = 0;
      while (!(bus.mem_read || bus.mem_write) && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      check("issue_latency", 64'(cyc), 64'(1));
      if (cyc >= 40) begin
         clear_reqs();
         return;
      end
      last_dut_g = int'(grant_id);
      check("grant_id", 64'(grant_id), 64'(g));
      check("mem_read", 64'(bus.mem_read), 64'(is_rd));
      check("mem_write", 64'(bus.mem_write), 64'(!is_rd));
      dly = (ack_dly >= 0) ? ack_dly : int'($urandom_range(0, 3));
      for (int i = 0; i < dly; i++) begin
         bus.mem_rdata_valid = 1'($urandom_range(0, 1));
         #1;
         check("ack_early", 64'(bus.req_ack), 64'(0));
         check("rv_in_issue", 64'(bus.req_rdata_valid), 64'(0));
         check("req_held", 64'(bus.mem_read | bus.mem_write), 64'(1));
         @(negedge clk);
      end
      bus.mem_rdata_valid = 1'b0;
      bus.mem_ack         = 1'b1;
      #1;
      check("req_ack", 64'(bus.req_ack), 64'(1) << g);
      @(negedge clk);
      bus.mem_ack = 1'b0;
      rd_m[g]     = 1'b0;
      wr_m[g]     = 1'b0;
      if (allow_new) add_random(g);
      apply_reqs();
      // Address beat
      d = $urandom;
      bus.req_wdata[g] = d;
      scramble(g);
      #1;
      check("addr_beat", 64'(bus.mem_wdata), 64'(d));
      check("mem_req_clear", 64'(bus.mem_read | bus.mem_write), 64'(0));
      @(negedge clk);
      if (!is_rd) begin
         for (int i = 0; i < NB; i++) begin
            d = directed ? W'(32'hA0 + i) : W'($urandom);
            bus.req_wdata[g] = d;
            scramble(g);
            bus.mem_ack = 1'($urandom_range(0, 1));
            #1;
            check("wbeat", 64'(bus.mem_wdata), 64'(d));
            check("busy_w", 64'(busy), 64'(1));
            check("wr_no_req", 64'(bus.mem_read | bus.mem_write), 64'(0));
            @(negedge clk);
         end
      end else begin
         b   = 0;
         cyc = 0;
         gap = 0;
         while (b < NB && cyc < 200) begin
            v = (gap >= 3) || ($urandom_range(0, 2) != 0);
            d = directed ? W'(32'h11 * (b + 1)) : W'($urandom);
            bus.mem_rdata       = d;
            bus.mem_rdata_valid = v;
            bus.mem_ack         = 1'($urandom_range(0, 1));
            #1;
            check("rvalid", 64'(bus.req_rdata_valid), v ? (64'(1) << g) : 64'(0));
            if (v) check("rdata", 64'(bus.req_rdata), 64'(d));
            b   = b + int'(v);
            gap = v ? 0 : gap + 1;
            cyc++;
            @(negedge clk);
         end
      end
      bus.mem_ack         = 1'b0;
      bus.mem_rdata_valid = 1'b0;
      #1;
      check("idle_busy", 64'(busy), 64'(0));
      check("idle_wdata", 64'(bus.mem_wdata), 64'(0));
      check("grant_hold", 64'(grant_id), 64'(g));
      rr_m = (g + 1) % NUM_REQ;
   endtask

   task automatic serve_all();
      int n;
      n = 0;
      while (any_pending() && n < 30) begin
         serve_one();
         n++;
      end
      clear_reqs();
   endtask

`ifdef RVTU_ARB_TIMEOUT_EN
   task automatic timeout_test();
      int cyc;
      check("terr_pre", 64'(timeout_err), 64'(0));
      rd_m[1] = 1'b1;
      apply_reqs();
      cyc = 0;
      while (!bus.mem_read && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      check("to_issue", 64'(cyc), 64'(1));
      bus.mem_ack = 1'b1;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      rd_m[1]     = 1'b0;
      apply_reqs();
      bus.req_wdata[1] = 32'h0000_1000;
      @(negedge clk);
      bus.mem_rdata       = 32'h5A5A_0001;
      bus.mem_rdata_valid = 1'b1;
      #1;
      check("to_real_v", 64'(bus.req_rdata_valid), 64'(4'b0010));
      check("to_real_d", 64'(bus.req_rdata), 64'(32'h5A5A_0001));
      @(negedge clk);
      bus.mem_rdata_valid = 1'b0;
      bus.mem_rdata       = 32'hDEAD_BEEF;
      cyc = 0;
      #1;
      while (bus.req_rdata_valid == '0 && cyc < 50) begin
         @(negedge clk);
         #1;
         cyc++;
      end
      check("to_gap", 64'(cyc), 64'(TO));
      for (int s = 0; s < NB - 1; s++) begin
         check("to_synth_v", 64'(bus.req_rdata_valid), 64'(4'b0010));
         check("to_synth_d", 64'(bus.req_rdata), 64'(0));
         @(negedge clk);
         #1;
      end
      check("to_idle", 64'(busy), 64'(0));
      check("terr_set", 64'(timeout_err), 64'(1));
      rr_m    = 2;
      rd_m[3] = 1'b1;
      apply_reqs();
      serve_all();
      check("terr_sticky", 64'(timeout_err), 64'(1));
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("terr_rst", 64'(timeout_err), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      rr_m  = 0;
      @(negedge clk);
      #1;
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      n_tests   = 0;
      n_fail    = 0;
      rr_m      = 0;
      ack_dly   = -1;
      directed  = 1'b0;
      allow_new = 1'b0;
      rst_n     = 1'b0;
      bus.req_read        = '0;
      bus.req_write       = '0;
      bus.req_wdata       = '0;
      bus.mem_ack         = 1'b0;
      bus.mem_rdata       = '0;
      bus.mem_rdata_valid = 1'b0;
      clear_reqs();

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_grant", 64'(grant_id), 64'(0));
      check("rst_mem_req", 64'({bus.mem_read, bus.mem_write}), 64'(0));
      check("rst_ack", 64'(bus.req_ack), 64'(0));
      check("rst_rvalid", 64'(bus.req_rdata_valid), 64'(0));
      check("rst_wdata", 64'(bus.mem_wdata), 64'(0));
`ifdef RVTU_ARB_TIMEOUT_EN
      check("rst_terr", 64'(timeout_err), 64'(0));
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;

      // Single read from requester 2, ack after 3 cycles, beats 0x11..0x44
      directed = 1'b1;
      ack_dly  = 3;
      rd_m[2]  = 1'b1;
      apply_reqs();
      serve_all();
      // Single write from requester 0, beats 0xA0..0xA3
      wr_m[0] = 1'b1;
      apply_reqs();
      serve_all();
      directed = 1'b0;
      ack_dly  = -1;
      // Write on requester 3 brings the pointer back to 0
      wr_m[3] = 1'b1;
      apply_reqs();
      serve_all();

      // All four read at once, twice: order 0,1,2,3 both rounds
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < NUM_REQ; i++) rd_m[i] = 1'b1;
         apply_reqs();
         for (int k = 0; k < NUM_REQ; k++) begin
            serve_one();
            check("rr_order", 64'(last_dut_g), 64'(k));
         end
         clear_reqs();
      end

      // Read and write together on requester 1: served as a read
      rd_m[1] = 1'b1;
      wr_m[1] = 1'b1;
      apply_reqs();
      serve_all();

      // Reset during the third write beat of requester 2
      wr_m[2] = 1'b1;
      apply_reqs();
      cyc = 0;
      while (!bus.mem_write && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      check("rst_tx_issue", 64'(cyc), 64'(1));
      bus.mem_ack = 1'b1;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      wr_m[2]     = 1'b0;
      apply_reqs();
      bus.req_wdata[2] = 32'hCAFE_0000;
      repeat (3) begin
         @(negedge clk);
         bus.req_wdata[2] = $urandom;
      end
      rst_n = 1'b0;
      #1;
      check("midrst_busy", 64'(busy), 64'(0));
      check("midrst_mem_req", 64'({bus.mem_read, bus.mem_write}), 64'(0));
      check("midrst_wdata", 64'(bus.mem_wdata), 64'(0));
      check("midrst_grant", 64'(grant_id), 64'(0));
      clear_reqs();
      rr_m = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      rd_m[1] = 1'b1;
      rd_m[3] = 1'b1;
      apply_reqs();
      serve_one();
      check("post_rst_grant", 64'(last_dut_g), 64'(1));
      serve_all();

      // Randomized rounds with requests arriving while busy
      allow_new = 1'b1;
      for (int r = 0; r < 40; r++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            cyc     = int'($urandom_range(0, 3));
            rd_m[i] = (cyc == 1 || cyc == 3);
            wr_m[i] = (cyc == 2 || cyc == 3);
         end
         if (!any_pending()) rd_m[$urandom_range(0, NUM_REQ - 1)] = 1'b1;
         apply_reqs();
         serve_all();
      end
      allow_new = 1'b0;

`ifdef RVTU_ARB_TIMEOUT_EN
      timeout_test();
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
